// File: rtl/bus_arbiter.sv
// Four-requester round-robin bus arbiter with a bounded hold time.
// An owner is preempted after MAX_HOLD cycles while others are waiting.
module bus_arbiter #(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [3:0]       grant,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             preempt
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q;
  logic [3:0] grant_q;
  logic [1:0] owner_q;
  logic [1:0] last_q;
  logic [7:0] cnt_q;
  logic       busy_q;
  logic       preempt_q;

  logic [1:0] win;
  logic       any_req;
  logic       others;

  // First set request scanning upward from last+1; the last owner itself is
  // checked last, so it only wins when it is the sole requester.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  assign win     = rr_pick(req, last_q);
  assign any_req = |req;
  assign others  = |(req & ~grant_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 4'b0000;
      owner_q   <= 2'd0;
      last_q    <= 2'd3;
      cnt_q     <= 8'd0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q <= OWN;
            grant_q <= onehot(win);
            owner_q <= win;
            last_q  <= win;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b1;
          end
        end
        OWN: begin
          if (!req[owner_q]) begin
            // Owner released; req[owner] is 0 so any winner is another requester.
            if (any_req) begin
              grant_q <= onehot(win);
              owner_q <= win;
              last_q  <= win;
              cnt_q   <= 8'd0;
            end else begin
              state_q <= IDLE;
              grant_q <= 4'b0000;
              cnt_q   <= 8'd0;
              busy_q  <= 1'b0;
            end
          end else if (cnt_q < HOLD_LAST) begin
            cnt_q <= cnt_q + 8'd1;
          end else if (others) begin
            grant_q   <= onehot(win);
            owner_q   <= win;
            last_q    <= win;
            cnt_q     <= 8'd0;
            preempt_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 4'b0000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    out = '0;
    case (grant_q)
      4'b0001: out = in0;
      4'b0010: out = in1;
      4'b0100: out = in2;
      4'b1000: out = in3;
      default: out = '0;
    endcase
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed vector table, rotation/saturation
// sequences and a glitch case, checked through an expectation queue.
module tb_bus_arbiter;
  localparam int WIDTH    = 16;
  localparam int MAX_HOLD = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req;
  logic [WIDTH-1:0] in0, in1, in2, in3;
  logic [3:0]       grant;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             preempt;

  always #5 clk = ~clk;

  bus_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .grant(grant), .out(out), .busy(busy), .preempt(preempt)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       pre;
  } vec_t;

  typedef struct {
    logic [3:0] grant;
    logic       pre;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [WIDTH-1:0] exp_out(input logic [3:0] g);
    case (g)
      4'b0001: return in0;
      4'b0010: return in1;
      4'b0100: return in2;
      4'b1000: return in3;
      default: return '0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check({e.name, ".grant"}, 32'(grant), 32'(e.grant));
      check({e.name, ".preempt"}, 32'(preempt), 32'(e.pre));
      check({e.name, ".busy"}, 32'(busy), 32'(e.grant != 4'b0000));
      check({e.name, ".out"}, 32'(out), 32'(exp_out(e.grant)));
      check({e.name, ".onehot0"}, 32'($onehot0(grant)), 32'd1);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q, input logic [3:0] g,
                      input logic p, input string name);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = q;
    in0 = 16'($urandom);
    in1 = 16'($urandom);
    in2 = 16'($urandom);
    in3 = 16'($urandom);
    e.grant = g;
    e.pre   = p;
    e.name  = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  vec_t       vecs[21];
  logic [3:0] g;
  logic       p;

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    in0 = 16'hA000;
    in1 = 16'hB001;
    in2 = 16'hC002;
    in3 = 16'hD003;

    vecs = '{
      '{1'b1, 4'b0000, 4'b0000, 1'b0},  // reset
      '{1'b1, 4'b1111, 4'b0000, 1'b0},  // reset dominates requests
      '{1'b0, 4'b0110, 4'b0010, 1'b0},  // last=3 -> scan from 0, pick 1
      '{1'b0, 4'b0110, 4'b0010, 1'b0},  // hold
      '{1'b0, 4'b0100, 4'b0100, 1'b0},  // owner 1 releases -> 2
      '{1'b0, 4'b0000, 4'b0000, 1'b0},  // idle
      '{1'b0, 4'b1000, 4'b1000, 1'b0},  // grant 3
      '{1'b0, 4'b0001, 4'b0001, 1'b0},  // 3 drops -> wrap to 0
      '{1'b0, 4'b0000, 4'b0000, 1'b0},  // all drop -> idle, out 0
      '{1'b0, 4'b1011, 4'b0010, 1'b0},  // last=0 -> pick 1
      '{1'b0, 4'b1001, 4'b1000, 1'b0},  // 1 drops -> scan 2,3 -> 3
      '{1'b0, 4'b0011, 4'b0001, 1'b0},  // 3 drops, 1 reasserts -> 0 first
      '{1'b0, 4'b0011, 4'b0001, 1'b0},  // hold
      '{1'b0, 4'b0010, 4'b0010, 1'b0},  // 0 drops -> 1
      '{1'b1, 4'b0010, 4'b0000, 1'b0},  // reset mid-ownership
      '{1'b0, 4'b0110, 4'b0010, 1'b0},  // last back to 3 -> 1
      '{1'b0, 4'b0000, 4'b0000, 1'b0},
      '{1'b0, 4'b0100, 4'b0100, 1'b0},  // grant 2
      '{1'b1, 4'b0101, 4'b0000, 1'b0},  // reset drops grant
      '{1'b0, 4'b0101, 4'b0001, 1'b0},  // resumes favouring 0
      '{1'b0, 4'b0000, 4'b0000, 1'b0}
    };

    for (int i = 0; i < 21; i++)
      step(vecs[i].rst, vecs[i].req, vecs[i].grant, vecs[i].pre,
           $sformatf("vec%0d", i));

    // Request glitch between edges must not produce a grant.
    begin
      exp_t e;
      @(negedge clk);
      rst = 1'b0;
      req = 4'b0000;
      e.grant = 4'b0000;
      e.pre   = 1'b0;
      e.name  = "glitch";
      sb.push_back(e);
      #1 req = 4'b1111;
      #2 req = 4'b0000;
      @(posedge clk);
      #1;
      pop_check();
    end

    // All four requesting: 8 cycles each, preempt pulse at each switch.
    step(1'b1, 4'b0000, 4'b0000, 1'b0, "rot_rst");
    for (int e = 0; e < 40; e++) begin
      g = 4'b0001 << ((e / 8) % 4);
      p = (e % 8 == 0) && (e > 0);
      step(1'b0, 4'b1111, g, p, $sformatf("rot%0d", e));
    end

    // Lone owner holds indefinitely; saturated counter preempts at once.
    step(1'b0, 4'b0000, 4'b0000, 1'b0, "sat_idle");
    for (int c = 0; c < 20; c++)
      step(1'b0, 4'b0100, 4'b0100, 1'b0, $sformatf("sat%0d", c));
    step(1'b0, 4'b0101, 4'b0001, 1'b1, "sat_preempt");
    step(1'b0, 4'b0101, 4'b0001, 1'b0, "sat_after");
    step(1'b0, 4'b0000, 4'b0000, 1'b0, "final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
